// File: rtl/data_mem_ctrl_if.sv
// Request/response bundle between the MEM stage and the data memory.
// Carries the load/store handshake, registered load result and clear control.
interface data_mem_ctrl_if;
  logic        req_valid;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] addr;
  logic [31:0] din;
  logic        req_ready;
  logic [31:0] rdata;
  logic        rvalid;
  logic        misalign;
  logic        clr_start;
  logic        busy;

  modport master (
    output req_valid, req_write, req_size, req_signed,
    output addr, din, clr_start,
    input  req_ready, rdata, rvalid, misalign, busy
  );

  modport slave (
    input  req_valid, req_write, req_size, req_signed,
    input  addr, din, clr_start,
    output req_ready, rdata, rvalid, misalign, busy
  );
endinterface

// File: rtl/data_mem_ctrl.sv
// Data memory controller: byte/half/word access, registered loads,
// misalignment faults and a one-word-per-cycle clear sweep.
module data_mem_ctrl #(
  parameter int DEPTH = 1024,
  parameter int AW = $clog2(DEPTH),
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input logic clk,
  input logic reset,
  data_mem_ctrl_if.slave bus
);

  typedef enum logic {
    IDLE,
    CLEAR
  } state_t;

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  state_t        state, state_d;
  logic [AW-1:0] clr_ptr, ptr_d;
  logic [31:0]   mem [DEPTH];

  logic          acc;
  logic          fault;
  logic [AW-1:0] idx;
  logic [1:0]    lane;
  logic [31:0]   word;
  logic [31:0]   wdata;
  logic [3:0]    be;
  logic [7:0]    ld_b;
  logic [15:0]   ld_h;
  logic [31:0]   ld_val;
  logic          unused_hi;

  assign bus.busy      = (state == CLEAR);
  assign bus.req_ready = !bus.busy;
  assign acc           = bus.req_valid && bus.req_ready;
  assign idx           = bus.addr[AW+1:2];
  assign lane          = bus.addr[1:0];
  assign word          = mem[idx];
  // Upper address bits alias silently.
  assign unused_hi     = ^bus.addr[31:AW+2];

  // Alignment fault decode; size 11 always faults.
  always_comb begin
    fault = 1'b0;
    unique case (bus.req_size)
      2'b00:   fault = 1'b0;
      2'b01:   fault = lane[0];
      2'b10:   fault = |lane;
      default: fault = 1'b1;
    endcase
  end

  // Lane enables; store data is replicated so every lane sees its bits.
  always_comb begin
    be    = 4'b0000;
    wdata = bus.din;
    unique case (bus.req_size)
      2'b00: begin
        be    = 4'b0001 << lane;
        wdata = {4{bus.din[7:0]}};
      end
      2'b01: begin
        be    = lane[1] ? 4'b1100 : 4'b0011;
        wdata = {2{bus.din[15:0]}};
      end
      2'b10:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  // Right-align the selected lane(s) and extend.
  always_comb begin
    ld_b   = word[{lane, 3'b000} +: 8];
    ld_h   = lane[1] ? word[31:16] : word[15:0];
    ld_val = word;
    unique case (bus.req_size)
      2'b00:   ld_val = {{24{bus.req_signed & ld_b[7]}}, ld_b};
      2'b01:   ld_val = {{16{bus.req_signed & ld_h[15]}}, ld_h};
      default: ld_val = word;
    endcase
  end

  // Storage array: sweep writes take priority, stores are lane-masked.
  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      mem[clr_ptr] <= '0;
    end else if (acc && bus.req_write && !fault) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  // Clear-engine state and pointer registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= CLEAR_ON_RESET ? CLEAR : IDLE;
      clr_ptr <= '0;
    end else begin
      state   <= state_d;
      clr_ptr <= ptr_d;
    end
  end

  // Clear-engine next state: start on request, stop after the last word.
  always_comb begin
    state_d = state;
    ptr_d   = clr_ptr;
    unique case (state)
      IDLE: begin
        ptr_d = '0;
        if (bus.clr_start) state_d = CLEAR;
      end
      CLEAR: begin
        ptr_d = clr_ptr + 1'b1;
        if (clr_ptr == LAST) begin
          state_d = IDLE;
          ptr_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        ptr_d   = '0;
      end
    endcase
  end

  // Registered response: load data, valid and fault strobes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.rdata    <= '0;
      bus.rvalid   <= 1'b0;
      bus.misalign <= 1'b0;
    end else begin
      bus.rvalid   <= acc && !bus.req_write;
      bus.misalign <= acc && fault;
      if (acc && !bus.req_write) begin
        bus.rdata <= fault ? 32'h0 : ld_val;
      end
    end
  end

endmodule

// File: doc/data_mem_ctrl.md
Name: data_mem_ctrl

Overview:
- Parametrised successor to the single-cycle word data memory in the KGP-RISC datapath.
- Adds byte/half/word access with sign or zero extension, a registered read port with a valid strobe, and misalignment detection.
- Adds a sequential clear engine that zeroes the array one word per cycle, after reset or on request, with a busy/ready handshake toward the core.
- Sits between the core's MEM stage and the storage array.

Parameters:
- DEPTH, 1024: number of 32-bit words; must be a power of two.
- AW, $clog2(DEPTH): word-index width (derived; do not override).
- CLEAR_ON_RESET, 1: 1 = run a clear sweep automatically after reset release; 0 = come out of reset idle, array contents undefined.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  access request.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  00 = byte, 01 = half, 10 = word, 11 = reserved.
- req_signed  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
- addr  in  32  byte address.
- din  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- req_ready  out  1  request may be accepted; equals !busy (combinational).
- rdata  out  32  load result, registered.
- rvalid  out  1  one-cycle strobe: rdata is valid.
- misalign  out  1  one-cycle strobe: the accepted request faulted.
- clr_start  in  1  request a clear sweep.
- busy  out  1  clear sweep in progress, registered.

Behaviour:
- Reset (reset=0, asynchronous):
  - rdata=0, rvalid=0, misalign=0, clr_ptr=0.
  - state=CLEAR and busy=1 if CLEAR_ON_RESET=1; otherwise state=IDLE and busy=0.
  - Array contents are not touched by reset itself.
  - Reset asserted mid-sweep restarts the sweep from word 0.
- FSM states: IDLE, CLEAR.
  - IDLE -> CLEAR when clr_start=1. busy=1 from the next cycle.
  - CLEAR: write 0 to word clr_ptr, then clr_ptr++. At clr_ptr==DEPTH-1, write it, go to IDLE, busy=0 next cycle.
  - A sweep takes exactly DEPTH cycles. clr_start is ignored while in CLEAR.
- Accept: a request is accepted when req_valid && req_ready; one access per cycle; single port.
  - Requests presented while busy=1 are not accepted; the requester holds them.
  - If clr_start and an accepted request occur in the same IDLE cycle, the request completes normally and the sweep begins next cycle.
- Addressing:
  - Word index = addr[AW+1:2]; lane offset = addr[1:0].
  - addr[31:AW+2] is ignored, so accesses alias modulo DEPTH*4 bytes without an error.
- Misalignment:
  - Faults: half with addr[0]=1; word with addr[1:0]!=0; req_size=11 at any address.
  - On a fault: no array write; misalign=1 on the cycle after acceptance.
  - If the faulting request is a load, rvalid=1 and rdata=0 on that same cycle.
- Stores: byte lanes are written on the clock edge of acceptance.
  - Byte: din[7:0] goes to lane addr[1:0].
  - Half: din[15:0] goes to lanes {addr[1],0} and {addr[1],1}.
  - Word: all four lanes.
  - Little-endian: lane 0 = bits [7:0].
  - Unselected lanes hold their value.
  - rvalid stays 0 for stores.
- Loads:
  - 1-cycle latency: rdata and rvalid=1 are registered on the edge after acceptance.
  - The selected byte or half is right-aligned, then sign-extended (req_signed=1) or zero-extended (req_signed=0).
  - req_signed is ignored for word loads.
  - rdata holds its value until the next load completes; rvalid is 0 on all other cycles.
- Ordering: a load accepted the cycle after a store to the same word returns the updated data. No same-cycle read/write case exists because the port is single-access.

Test Plan:
- Reset with CLEAR_ON_RESET=1, DEPTH=16 -> busy=1 and req_ready=0 for exactly 16 cycles, then busy=0; word loads at 0x00..0x3C all return 0.
- Store word 0x8899AABB at 0x40, then load byte signed at 0x41 -> rdata=0xFFFFFFAA, rvalid high for 1 cycle; byte unsigned at 0x43 -> 0x00000088; half signed at 0x42 -> 0xFFFF8899.
- Store byte din=0x123456CD at 0x45 over word 0 -> word load at 0x44 returns 0x0000CD00; a following store half 0xBEEF at 0x46 -> 0xBEEFCD00.
- Misaligned: word load at 0x2 -> misalign=1, rvalid=1, rdata=0; half store at 0x7 -> misalign=1, rvalid=0, word at 0x4 unchanged; req_size=11 at 0x0 -> misalign=1.
- Sweep interaction:
  - Assert clr_start while a load of 0x40 is accepted -> load returns its stored data, then busy=1.
  - Hold req_valid during the sweep -> req_ready=0, not accepted until busy drops.
  - Assert reset at mid-sweep -> sweep restarts from word 0, still DEPTH cycles.
- Aliasing with DEPTH=16: store word 0xCAFEF00D at 0x40 -> word load at 0x00 returns 0xCAFEF00D.
